// File: rtl/chirp_seq_pkg.sv
// Shared types and default sizing for the chirp sequencer and its timer.
package chirp_seq_pkg;

  localparam int CNT_W_DEF         = 16;
  localparam int PRI_W_DEF         = 32;
  localparam int DLY_W_DEF         = 16;
  localparam int READY_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_RDY,
    S_PRE,
    S_CHIRP,
    S_POST,
    S_END,
    S_PRI_WAIT
  } seq_state_e;

endpackage

// File: rtl/chirp_seq_timer.sv
// Loadable down-counter that parks at zero; zero flag is decoded from the count register.
module chirp_seq_timer #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/chirp_sequencer.sv
// Burst sequencer for the chirp DDS and ADC capture gates, enforcing the PRI between chirps.
module chirp_sequencer
  import chirp_seq_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int PRI_W         = PRI_W_DEF,
  parameter int DLY_W         = DLY_W_DEF,
  parameter int READY_TIMEOUT = READY_TIMEOUT_DEF
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_chirps,
  input  logic [PRI_W-1:0] pri_period,
  input  logic [DLY_W-1:0] adc_pre_dly,
  input  logic [DLY_W-1:0] adc_post_dly,
  input  logic             chirp_ready,
  input  logic             chirp_done,
  output logic             chirp_init,
  output logic             chirp_enable,
  output logic             adc_enable,
  output logic             busy,
  output logic [CNT_W-1:0] chirp_index,
  output logic             seq_done,
  output logic             err_overrun,
  output logic             err_timeout
);

  localparam int TO_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;

  seq_state_e       state, next_state;
  logic [CNT_W-1:0] num_q;
  logic [PRI_W-1:0] pri_q, pri_cnt, pri_inc;
  logic [DLY_W-1:0] pre_q, post_q, dly_val;
  logic             stop_pend, dly_load, dly_zero, rdy_zero;
  logic             last_chirp, seq_end, set_timeout, set_overrun, advance;

  chirp_seq_timer #(.W(DLY_W)) u_dly_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (dly_load),
    .load_val (dly_val),
    .zero     (dly_zero)
  );

  // Loaded with READY_TIMEOUT-1 so it hits zero on the READY_TIMEOUT-th WAIT_RDY cycle.
  chirp_seq_timer #(.W(TO_W)) u_rdy_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (state == S_INIT),
    .load_val (TO_W'(READY_TIMEOUT - 1)),
    .zero     (rdy_zero)
  );

  assign pri_inc    = (pri_cnt == '1) ? pri_cnt : pri_cnt + PRI_W'(1);
  assign last_chirp = (num_q != '0) && ((chirp_index + CNT_W'(1)) == num_q);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    dly_load    = 1'b0;
    dly_val     = '0;
    seq_end     = 1'b0;
    set_timeout = 1'b0;
    set_overrun = 1'b0;
    advance     = 1'b0;
    case (state)
      S_IDLE:     if (start) next_state = S_INIT;
      S_INIT:     next_state = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (chirp_ready) begin
          if (pre_q == '0) begin
            next_state = S_CHIRP;
          end else begin
            next_state = S_PRE;
            dly_load   = 1'b1;
            dly_val    = pre_q - DLY_W'(1);
          end
        end else if (rdy_zero) begin
          set_timeout = 1'b1;
          seq_end     = 1'b1;
          next_state  = S_IDLE;
        end
      end
      S_PRE:      if (dly_zero) next_state = S_CHIRP;
      S_CHIRP: begin
        if (chirp_done) begin
          if (post_q == '0) begin
            next_state = S_END;
          end else begin
            next_state = S_POST;
            dly_load   = 1'b1;
            dly_val    = post_q - DLY_W'(1);
          end
        end
      end
      S_POST:     if (dly_zero) next_state = S_END;
      S_END: begin
        if (last_chirp || stop_pend || stop) begin
          seq_end    = 1'b1;
          next_state = S_IDLE;
        end else begin
          advance    = 1'b1;
          next_state = S_PRI_WAIT;
          // pri_inc is the PRI count seen on the first PRI_WAIT cycle.
          set_overrun = (pri_q != '0) && (pri_inc >= pri_q);
        end
      end
      S_PRI_WAIT: if (pri_inc >= pri_q) next_state = S_INIT;
      default:    next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they decode.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      chirp_init   <= 1'b0;
      chirp_enable <= 1'b0;
      adc_enable   <= 1'b0;
      busy         <= 1'b0;
      seq_done     <= 1'b0;
      chirp_index  <= '0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;
      stop_pend    <= 1'b0;
      pri_cnt      <= '0;
      num_q        <= '0;
      pri_q        <= '0;
      pre_q        <= '0;
      post_q       <= '0;
    end else begin
      chirp_init   <= (next_state == S_INIT);
      chirp_enable <= (next_state == S_CHIRP);
      adc_enable   <= (next_state == S_PRE) || (next_state == S_CHIRP) || (next_state == S_POST);
      busy         <= (next_state != S_IDLE);
      seq_done     <= seq_end;

      if (state == S_IDLE)      pri_cnt <= '0;
      else if (state == S_INIT) pri_cnt <= PRI_W'(1);
      else                      pri_cnt <= pri_inc;

      if (state == S_IDLE && start) begin
        num_q       <= num_chirps;
        pri_q       <= pri_period;
        pre_q       <= adc_pre_dly;
        post_q      <= adc_post_dly;
        chirp_index <= '0;
        err_overrun <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (advance)     chirp_index <= chirp_index + CNT_W'(1);
      if (set_timeout) err_timeout <= 1'b1;
      if (set_overrun) err_overrun <= 1'b1;

      if (next_state == S_IDLE)            stop_pend <= 1'b0;
      else if (stop && state != S_IDLE)    stop_pend <= 1'b1;
    end
  end

endmodule
